wbuart_mux: RTL
===============

Name: wbuart_mux

Overview:
- Shares one UART byte-stream PHY between a boot loader (byte-stream master, e.g. the intel-hex loader) and a Wishbone-slave console with buffered RX/TX FIFOs.
- Successor to the fixed loader/console switch: FIFO depth is parametrised, and software gets status, interrupt and control registers.
- Console mode can return to loader mode, either by a software CTRL write or by an in-band escape sequence on RX.

Parameters:
- FIFO_DEPTH, 16, RX and TX FIFO depth in bytes; power of 2, ≥2.
- ESC_CHAR, 8'h2B, escape byte that returns the block to loader mode.
- ESC_COUNT, 3, number of consecutive ESC_CHAR bytes that trigger loader mode; ≥1.

Ports:
- i_clk  in  1  clock; the block uses this one clock only.
- i_reset  in  1  asynchronous reset, active-high.
- i_rx_stb  in  1  PHY received-byte strobe.
- i_rx_data  in  8  PHY received byte.
- o_tx_stb  out  1  PHY transmit strobe.
- o_tx_data  out  8  PHY transmit byte.
- i_tx_busy  in  1  PHY transmitter busy.
- o_ldr_rx_stb  out  1  RX strobe to the loader.
- o_ldr_rx_data  out  8  RX byte to the loader.
- i_ldr_tx_stb  in  1  loader transmit strobe.
- i_ldr_tx_data  in  8  loader transmit byte.
- o_ldr_reset  out  1  holds the loader in reset.
- i_wb_cyc, i_wb_stb, i_wb_we  in  1 each  Wishbone slave controls (pipelined).
- i_wb_sel  in  4  byte selects.
- i_wb_addr  in  30  word address; only [1:0] decoded.
- i_wb_data  in  32  write data.
- o_wb_stall, o_wb_ack, o_wb_err  out  1 each  Wishbone responses.
- o_wb_data  out  32  read data.
- o_console_mode  out  1  1 = console mode.
- o_irq  out  1  level interrupt.

Behaviour:
- Reset values: console_mode=0, both FIFOs empty, sticky flags=0, CTRL=0, escape counter=0, TX FSM=IDLE, o_wb_ack=0, o_wb_data=0, o_tx_stb=0.
- Constant outputs: o_wb_stall=0 and o_wb_err=0 always.
- o_ldr_reset = i_reset | console_mode.
- Loader mode, RX path: o_ldr_rx_stb=i_rx_stb and o_ldr_rx_data=i_rx_data, both combinational. The RX FIFO is not written.
- Loader mode, TX path: o_tx_stb=i_ldr_tx_stb and o_tx_data=i_ldr_tx_data, both combinational.
- Console mode: o_ldr_rx_stb=0 and i_ldr_tx_* are ignored.
- Wishbone access is accepted when i_wb_cyc & i_wb_stb; o_wb_ack rises exactly 1 cycle later, and o_wb_data is registered and valid with ack.
- Register map by i_wb_addr[1:0]:
  - 0 DATA, read: pops the RX FIFO in the accept cycle and returns {23'b0, 1'b0, byte}. If the FIFO is empty, returns 32'h100 and does not pop.
  - 0 DATA, write with sel[0]: pushes data[7:0] into the TX FIFO. If the FIFO is full, the byte is dropped and tx_ovf is set.
  - 1 STATUS, read: [0] rx_nonempty, [1] tx_full, [2] rx_ovf, [3] tx_ovf, [4] console_mode, [5] tx_empty, [15:8] rx_count (zero-extended).
  - 1 STATUS, write: a 1 in bit 2 clears rx_ovf; a 1 in bit 3 clears tx_ovf.
  - 2 CTRL: [0] rx_ie, [1] tx_ie, both read/write. Writing bit 8 = 1 triggers a loader return; bit 8 reads 0.
  - 3: reads 0, writes ignored, still acked.
- Entering console mode: any accepted write sets console_mode=1 in the next cycle, except a CTRL write with bit 8 = 1, which forces console_mode=0.
- Escape, console mode: a counter increments on each received ESC_CHAR and clears on any other received byte.
  - On the ESC_COUNT-th consecutive ESC_CHAR, console_mode clears in the next cycle.
  - Escape bytes are also pushed into the RX FIFO, but they are lost because of the flush below.
- Loader return (escape or CTRL): both FIFOs are flushed, the escape counter clears, and the TX FSM goes to IDLE. Sticky flags and CTRL bits are kept. A byte already in the PHY completes.
- Simultaneous accepted write and escape completion: the write wins, and console_mode stays 1.
- RX FIFO, console mode: each i_rx_stb pushes one byte. If the FIFO is full and no pop occurs in the same cycle, the byte is dropped and rx_ovf is set. A push and pop in the same cycle both take effect, including when the FIFO is full.
- TX drain FSM (console mode only):
  - IDLE → SEND when the TX FIFO is nonempty & !i_tx_busy.
  - SEND: o_tx_stb=1 for one cycle with the head byte, pop → HOLD.
  - HOLD: one cycle, lets the PHY raise busy → IDLE.
- o_irq = (rx_ie & rx_nonempty) | (tx_ie & tx_empty & console_mode), computed combinationally from registers.

Decomposition:
- Package wbuart_mux_pkg: register address constants (REG_DATA=2'd0, REG_STATUS=2'd1, REG_CTRL=2'd2), STATUS/CTRL bit-index constants, the tx_state_t enum {IDLE, SEND, HOLD}, and the RX_EMPTY_FLAG constant.
- One sub-module: sync_fifo (params WIDTH, DEPTH; ports push, pop, flush, full, empty, count, dout at head). It is instantiated twice.

Test Plan:
- After reset, send rx bytes 0x3A,0x31 → o_ldr_rx_stb pulses twice with the same data; o_ldr_reset=0; STATUS reads 0x00000020.
- WB write DATA=0x41 → console_mode=1 next cycle, o_ldr_reset=1, and after busy is low one o_tx_stb with 0x41. With i_ldr_tx_stb driven, o_tx_stb does not follow the loader.
- In console mode, push 17 rx bytes into a 16-deep FIFO → STATUS bit2=1, rx_count=16; 17 DATA reads return bytes 1..16, then 0x100. Writing STATUS 0x4 clears bit2.
- In console mode, rx 0x2B,0x2B,0x41,0x2B,0x2B,0x2B → loader mode after the 6th byte only; FIFOs are empty.
- Set CTRL=0x1, then rx one byte → o_irq=1. A DATA read → o_irq=0. Writing CTRL 0x100 → console_mode=0 and TX FIFO flushed.
- Assert i_reset mid-SEND with 5 bytes queued → all outputs take reset values immediately (asynchronous), and no further o_tx_stb occurs.

Source files
------------

// File: rtl/wbuart_mux_pkg.sv
// Shared constants and types for the loader/console UART multiplexer.
// Register map, STATUS/CTRL bit positions and the TX drain state encoding.
package wbuart_mux_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int ST_RX_NONEMPTY  = 0;
  localparam int ST_TX_FULL      = 1;
  localparam int ST_RX_OVF       = 2;
  localparam int ST_TX_OVF       = 3;
  localparam int ST_CONSOLE      = 4;
  localparam int ST_TX_EMPTY     = 5;
  localparam int ST_RX_COUNT_LSB = 8;

  localparam int CT_RX_IE   = 0;
  localparam int CT_TX_IE   = 1;
  localparam int CT_LDR_RET = 8;

  localparam logic [31:0] RX_EMPTY_FLAG = 32'h0000_0100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } tx_state_t;

endpackage

// File: rtl/wbuart_mux_sync_fifo.sv
// Single-clock FIFO with head-of-queue output and a synchronous flush.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [WIDTH-1:0]         dout_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q;
  logic [AW-1:0]    rdPtr_q;
  logic [AW:0]      count_q;
  logic             doPush;
  logic             doPop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign doPop   = pop_i & ~empty_o;
  assign doPush  = push_i & (~full_o | doPop);
  assign count_o = count_q;
  assign dout_o  = mem_q[rdPtr_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
      count_q <= count_q + (AW+1)'(doPush) - (AW+1)'(doPop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (doPush & ~flush_i) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/wbuart_mux.sv
// Shares one UART PHY between a byte-stream boot loader and a Wishbone console.
// Console mode is entered by any bus write and left by CTRL bit 8 or an RX escape run.
module wbuart_mux
  import wbuart_mux_pkg::*;
#(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [7:0]  ESC_CHAR   = 8'h2B,
  parameter int          ESC_COUNT  = 3
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_rx_stb,
  input  logic [7:0]  i_rx_data,
  output logic        o_tx_stb,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_busy,
  output logic        o_ldr_rx_stb,
  output logic [7:0]  o_ldr_rx_data,
  input  logic        i_ldr_tx_stb,
  input  logic [7:0]  i_ldr_tx_data,
  output logic        o_ldr_reset,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [3:0]  i_wb_sel,
  input  logic [29:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic        o_wb_stall,
  output logic        o_wb_ack,
  output logic        o_wb_err,
  output logic [31:0] o_wb_data,
  output logic        o_console_mode,
  output logic        o_irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = (ESC_COUNT > 1) ? $clog2(ESC_COUNT) : 1;

  logic          consoleMode_q, consoleMode_d;
  logic          rxOvf_q, rxOvf_d, txOvf_q, txOvf_d;
  logic          rxIe_q, rxIe_d, txIe_q, txIe_d;
  logic [EW-1:0] escCnt_q, escCnt_d;
  tx_state_t     txState_q, txState_d;
  logic          wbAck_q;
  logic [31:0]   wbData_q, rdData;

  logic          wbAccept, wbWrite, wbRead;
  logic [1:0]    wbAddr;
  logic          ctrlReturn, escHit, escFire, ldrReturn;
  logic          rxPush, rxPop, txPush, txPop;
  logic          rxFull, rxEmpty, txFull, txEmpty;
  logic [CW-1:0] rxCount, unusedTxCount;
  logic [7:0]    rxHead, txHead;
  logic          unusedBits;

  assign unusedBits = &{1'b0, i_wb_addr[29:2], i_wb_sel[3:1], i_wb_data[31:9], unusedTxCount};

  assign wbAccept   = i_wb_cyc & i_wb_stb;
  assign wbWrite    = wbAccept & i_wb_we;
  assign wbRead     = wbAccept & ~i_wb_we;
  assign wbAddr     = i_wb_addr[1:0];
  assign ctrlReturn = wbWrite & (wbAddr == REG_CTRL) & i_wb_data[CT_LDR_RET];
  assign escHit     = consoleMode_q & i_rx_stb & (i_rx_data == ESC_CHAR);
  assign escFire    = escHit & (escCnt_q == EW'(ESC_COUNT - 1));
  // A bus write in the same cycle as a completed escape keeps console mode, so no flush either.
  assign ldrReturn  = ctrlReturn | (escFire & ~wbWrite);

  assign rxPush = consoleMode_q & i_rx_stb;
  assign rxPop  = wbRead & (wbAddr == REG_DATA) & ~rxEmpty;
  assign txPush = wbWrite & (wbAddr == REG_DATA) & i_wb_sel[0] & ~txFull;
  assign txPop  = (txState_q == SEND);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i(i_clk), .rst_i(i_reset), .push_i(rxPush), .pop_i(rxPop), .flush_i(ldrReturn),
    .data_i(i_rx_data), .full_o(rxFull), .empty_o(rxEmpty), .count_o(rxCount), .dout_o(rxHead)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i(i_clk), .rst_i(i_reset), .push_i(txPush), .pop_i(txPop), .flush_i(ldrReturn),
    .data_i(i_wb_data[7:0]), .full_o(txFull), .empty_o(txEmpty), .count_o(unusedTxCount),
    .dout_o(txHead)
  );

  always_comb begin
    consoleMode_d = consoleMode_q;
    rxOvf_d       = rxOvf_q;
    txOvf_d       = txOvf_q;
    rxIe_d        = rxIe_q;
    txIe_d        = txIe_q;
    escCnt_d      = escCnt_q;

    if (ctrlReturn)   consoleMode_d = 1'b0;
    else if (wbWrite) consoleMode_d = 1'b1;
    else if (escFire) consoleMode_d = 1'b0;

    if (wbWrite && wbAddr == REG_STATUS) begin
      if (i_wb_data[ST_RX_OVF]) rxOvf_d = 1'b0;
      if (i_wb_data[ST_TX_OVF]) txOvf_d = 1'b0;
    end
    if (rxPush & rxFull & ~rxPop) rxOvf_d = 1'b1;
    if (wbWrite && wbAddr == REG_DATA && i_wb_sel[0] && txFull) txOvf_d = 1'b1;

    if (wbWrite && wbAddr == REG_CTRL) begin
      rxIe_d = i_wb_data[CT_RX_IE];
      txIe_d = i_wb_data[CT_TX_IE];
    end

    if (ldrReturn | escFire | ~consoleMode_q) escCnt_d = '0;
    else if (rxPush)                          escCnt_d = escHit ? escCnt_q + EW'(1) : '0;
  end

  always_comb begin
    txState_d = txState_q;
    case (txState_q)
      IDLE:    if (consoleMode_q & ~txEmpty & ~i_tx_busy) txState_d = SEND;
      SEND:    txState_d = HOLD;
      HOLD:    txState_d = IDLE;
      default: txState_d = IDLE;
    endcase
    if (ldrReturn | ~consoleMode_q) txState_d = IDLE;
  end

  always_comb begin
    rdData = '0;
    case (wbAddr)
      REG_DATA:   rdData = rxEmpty ? RX_EMPTY_FLAG : {24'b0, rxHead};
      REG_STATUS: begin
        rdData[ST_RX_NONEMPTY]         = ~rxEmpty;
        rdData[ST_TX_FULL]             = txFull;
        rdData[ST_RX_OVF]              = rxOvf_q;
        rdData[ST_TX_OVF]              = txOvf_q;
        rdData[ST_CONSOLE]             = consoleMode_q;
        rdData[ST_TX_EMPTY]            = txEmpty;
        rdData[ST_RX_COUNT_LSB +: 8]   = 8'(rxCount);
      end
      REG_CTRL: begin
        rdData[CT_RX_IE] = rxIe_q;
        rdData[CT_TX_IE] = txIe_q;
      end
      default:    rdData = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) txState_q <= IDLE;
    else         txState_q <= txState_d;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      consoleMode_q <= 1'b0;
      rxOvf_q       <= 1'b0;
      txOvf_q       <= 1'b0;
      rxIe_q        <= 1'b0;
      txIe_q        <= 1'b0;
      escCnt_q      <= '0;
      wbAck_q       <= 1'b0;
      wbData_q      <= '0;
    end else begin
      consoleMode_q <= consoleMode_d;
      rxOvf_q       <= rxOvf_d;
      txOvf_q       <= txOvf_d;
      rxIe_q        <= rxIe_d;
      txIe_q        <= txIe_d;
      escCnt_q      <= escCnt_d;
      wbAck_q       <= wbAccept;
      wbData_q      <= wbRead ? rdData : '0;
    end
  end

  assign o_wb_stall     = 1'b0;
  assign o_wb_err       = 1'b0;
  assign o_wb_ack       = wbAck_q;
  assign o_wb_data      = wbData_q;
  assign o_console_mode = consoleMode_q;
  assign o_ldr_reset    = i_reset | consoleMode_q;
  assign o_ldr_rx_stb   = ~consoleMode_q & i_rx_stb;
  assign o_ldr_rx_data  = i_rx_data;
  assign o_tx_stb       = consoleMode_q ? (txState_q == SEND) : i_ldr_tx_stb;
  assign o_tx_data      = consoleMode_q ? txHead : i_ldr_tx_data;
  assign o_irq          = (rxIe_q & ~rxEmpty) | (txIe_q & txEmpty & consoleMode_q);

endmodule
